mem_bus_responder: RTL

Target-side responder for the rd/wr/addr/din/dout/wait_n/valid memory bus used between CPU-side masters and slow-clock peripherals. It backs the bus with an internal word RAM, accepts requests only on target clock-enable ticks, and returns read data with a fixed, parameterised latency and a bounded number of outstanding reads. It models the device end that a clock-domain freezer or bus master talks to, and serves both as a reusable register/RAM peripheral and as the verification model for bus-side blocks.

---
 rtl/mem_bus_if.sv | 16 +
 rtl/mem_bus_responder.sv | 66 ++++++
 2 files changed

// File: rtl/mem_bus_if.sv
// mem_bus_if: rd/wr/addr/din/dout/wait_n/valid memory bus with sticky error flag
interface mem_bus_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
);
  logic                  rd;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  wait_n;
  logic                  valid;
  logic                  err;
  modport master (output rd, wr, addr, din, input dout, wait_n, valid, err);
  modport slave (input rd, wr, addr, din, output dout, wait_n, valid, err);
endinterface

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: RAM-backed bus target with cen-gated, fixed-latency, bounded-outstanding reads
module mem_bus_responder #(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 2
) (
  input logic      clock,
  input logic      reset_n,
  input logic      cen,
  mem_bus_if.slave bus
);
  localparam int PW = $clog2(MAX_PENDING + 1);
  if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..8");
  end
  if (MAX_PENDING < 1 || MAX_PENDING > READ_LATENCY) begin : g_bad_pending
    $error("MAX_PENDING must be in 1..READ_LATENCY");
  end
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [PW-1:0]         pending;
  logic                  v_q  [READ_LATENCY];
  logic [DATA_WIDTH-1:0] d_q  [READ_LATENCY];
  logic                  v_in [READ_LATENCY];
  logic [DATA_WIDTH-1:0] d_in [READ_LATENCY];
  logic                  accept;
  logic                  rd_acc;
  logic                  ret;
  assign bus.wait_n = cen && (pending < PW'(MAX_PENDING));
  assign accept     = bus.wait_n & (bus.rd | bus.wr);
  assign rd_acc     = accept & bus.rd & ~bus.wr;
  assign ret        = cen & v_in[READ_LATENCY-1];
  // The last stage doubles as the dout/valid register, so L stages give L-edge latency
  assign bus.valid  = v_q[READ_LATENCY-1];
  assign bus.dout   = d_q[READ_LATENCY-1];
  always_comb begin
    v_in[0] = rd_acc;
    d_in[0] = mem[bus.addr];
    for (int i = 1; i < READ_LATENCY; i++) begin
      v_in[i] = v_q[i-1];
      d_in[i] = d_q[i-1];
    end
  end
  always_ff @(posedge clock)
    if (accept && bus.wr) mem[bus.addr] <= bus.din;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      bus.err <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        v_q[i] <= 1'b0;
        d_q[i] <= '0;
      end
    end else begin
      pending <= pending + PW'(rd_acc) - PW'(ret);
      bus.err <= bus.err | (accept & bus.rd & bus.wr);
      v_q[READ_LATENCY-1] <= ret;
      if (ret) d_q[READ_LATENCY-1] <= d_in[READ_LATENCY-1];
      if (cen)
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
          v_q[i] <= v_in[i];
          d_q[i] <= d_in[i];
        end
    end
  end
endmodule
